craps_engine: RTL and testbench

CRAPS_ENGINE -- requirements
Module: craps_engine

---
 rtl/craps_pkg.sv | 23 ++
 rtl/craps_sat_counter.sv | 31 +++
 rtl/craps_engine.sv | 127 ++++++++++++
 tb/tb_craps_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// Shared definitions for the craps engine: state encoding and the dice totals
// that decide a come-out or point roll.
package craps_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_POINT = 2'b01,
    ST_WIN   = 2'b10,
    ST_LOSE  = 2'b11
  } state_t;

  localparam int ROLL_2  = 2;
  localparam int ROLL_3  = 3;
  localparam int ROLL_7  = 7;
  localparam int ROLL_11 = 11;
  localparam int ROLL_12 = 12;

  // Two dice can only total 2..12; anything else is a malformed strobe.
  function automatic logic roll_in_range(input int sum);
    return (sum >= ROLL_2) && (sum <= ROLL_12);
  endfunction

endpackage

// File: rtl/craps_sat_counter.sv
// Saturating up-counter with synchronous clear (highest priority) and load-one.
// Used for the win/loss tallies and the per-round roll count.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_set,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_set) begin
      r_count <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/craps_engine.sv
// Craps round engine: come-out/point rules, optional point-phase roll limit,
// one-cycle result and error pulses, and saturating statistics.
module craps_engine
  import craps_pkg::*;
#(
  parameter int SUM_W     = 4,
  parameter int CNT_W     = 8,
  parameter int MAX_ROLLS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll_valid,
  input  logic [SUM_W-1:0] roll_sum,
  input  logic             clear_stats,
  output logic [1:0]       state,
  output logic [SUM_W-1:0] point,
  output logic             point_valid,
  output logic             result_valid,
  output logic             result_win,
  output logic             roll_err,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] losses,
  output logic [CNT_W-1:0] roll_count
);

  state_t           r_state;
  logic [SUM_W-1:0] r_point;
  logic             r_point_valid;
  logic             r_result_valid;
  logic             r_result_win;
  logic             r_roll_err;

  state_t w_next_state;
  logic   w_res, w_res_win, w_err, w_cnt_set, w_cnt_inc, w_latch_point;
  logic   w_timeout;
  int     w_sum, w_cnt, w_cnt_next;

  assign w_sum      = int'(roll_sum);
  assign w_cnt      = int'(roll_count);
  assign w_cnt_next = (&roll_count) ? w_cnt : w_cnt + 1;
  assign w_timeout  = (MAX_ROLLS != 0) && (w_cnt_next == MAX_ROLLS);

  // NOTE: every signal gets a default first so this block never infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_res         = 1'b0;
    w_res_win     = 1'b0;
    w_err         = 1'b0;
    w_cnt_set     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_latch_point = 1'b0;
    if (roll_valid) begin
      if (!roll_in_range(w_sum)) begin
        w_err = 1'b1;
      end else if (r_state != ST_POINT) begin
        // INIT, WIN and LOSE all treat the roll as a fresh come-out.
        w_cnt_set = 1'b1;
        if (w_sum == ROLL_7 || w_sum == ROLL_11) begin
          w_next_state = ST_WIN;
          w_res        = 1'b1;
          w_res_win    = 1'b1;
        end else if (w_sum == ROLL_2 || w_sum == ROLL_3 || w_sum == ROLL_12) begin
          w_next_state = ST_LOSE;
          w_res        = 1'b1;
        end else begin
          w_next_state  = ST_POINT;
          w_latch_point = 1'b1;
        end
      end else if (roll_sum == r_point) begin
        w_next_state = ST_WIN;
        w_res        = 1'b1;
        w_res_win    = 1'b1;
      end else if (w_sum == ROLL_7) begin
        w_next_state = ST_LOSE;
        w_res        = 1'b1;
      end else begin
        // Only non-resolving point rolls advance the count and can time out.
        w_cnt_inc = 1'b1;
        if (w_timeout) begin
          w_next_state = ST_LOSE;
          w_res        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_INIT;
      r_point        <= '0;
      r_point_valid  <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_win   <= 1'b0;
      r_roll_err     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_point_valid  <= (w_next_state == ST_POINT);
      r_result_valid <= w_res;
      r_roll_err     <= w_err;
      if (w_latch_point) r_point      <= roll_sum;
      if (w_res)         r_result_win <= w_res_win;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_wins (
    .clk(clk), .reset(reset), .i_clr(clear_stats), .i_set(1'b0),
    .i_inc(w_res & w_res_win), .o_count(wins)
  );

  sat_counter #(.WIDTH(CNT_W)) u_losses (
    .clk(clk), .reset(reset), .i_clr(clear_stats), .i_set(1'b0),
    .i_inc(w_res & ~w_res_win), .o_count(losses)
  );

  sat_counter #(.WIDTH(CNT_W)) u_roll_count (
    .clk(clk), .reset(reset), .i_clr(1'b0), .i_set(w_cnt_set),
    .i_inc(w_cnt_inc), .o_count(roll_count)
  );

  assign state        = r_state;
  assign point        = r_point;
  assign point_valid  = r_point_valid;
  assign result_valid = r_result_valid;
  assign result_win   = r_result_win;
  assign roll_err     = r_roll_err;

endmodule

// File: tb/tb_craps_engine.sv
// Bench for craps_engine: two configurations driven with identical stimulus,
// each checked every cycle against a rule-level model, plus pinned scenarios.
module tb_craps_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll_valid;
  logic [3:0] roll_sum;
  logic       clear_stats;

  logic [1:0] d0_state, d1_state;
  logic [3:0] d0_point, d1_point;
  logic       d0_pv, d1_pv, d0_rv, d1_rv, d0_rw, d1_rw, d0_err, d1_err;
  logic [7:0] d0_wins, d0_losses, d0_rc;
  logic [1:0] d1_wins, d1_losses, d1_rc;

  always #5 clk = ~clk;

  craps_engine #(.SUM_W(4), .CNT_W(8), .MAX_ROLLS(0)) dut0 (
    .clk(clk), .reset(reset), .roll_valid(roll_valid), .roll_sum(roll_sum),
    .clear_stats(clear_stats), .state(d0_state), .point(d0_point),
    .point_valid(d0_pv), .result_valid(d0_rv), .result_win(d0_rw),
    .roll_err(d0_err), .wins(d0_wins), .losses(d0_losses), .roll_count(d0_rc)
  );

  craps_engine #(.SUM_W(4), .CNT_W(2), .MAX_ROLLS(3)) dut1 (
    .clk(clk), .reset(reset), .roll_valid(roll_valid), .roll_sum(roll_sum),
    .clear_stats(clear_stats), .state(d1_state), .point(d1_point),
    .point_valid(d1_pv), .result_valid(d1_rv), .result_win(d1_rw),
    .roll_err(d1_err), .wins(d1_wins), .losses(d1_losses), .roll_count(d1_rc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level model: state 0=INIT 1=POINT 2=WIN 3=LOSE, one entry per DUT.
  int max_r[2] = '{0, 3};
  int cmax[2]  = '{255, 3};
  int m_state[2], m_point[2], m_rv[2], m_rw[2], m_err[2];
  int m_wins[2], m_losses[2], m_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_point[i] = 0; m_rv[i] = 0; m_rw[i] = 0; m_err[i] = 0;
      m_wins[i] = 0; m_losses[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input bit v, input int s, input bit c);
    for (int i = 0; i < 2; i++) begin
      bit res, win;
      res = 0; win = 0;
      m_rv[i] = 0; m_err[i] = 0;
      if (v) begin
        if (s < 2 || s > 12) begin
          m_err[i] = 1;
        end else if (m_state[i] != 1) begin
          m_cnt[i] = 1;
          if (s == 7 || s == 11) begin res = 1; win = 1; end
          else if (s == 2 || s == 3 || s == 12) res = 1;
          else begin m_state[i] = 1; m_point[i] = s; end
        end else if (s == m_point[i]) begin
          res = 1; win = 1;
        end else if (s == 7) begin
          res = 1;
        end else begin
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          if (max_r[i] != 0 && m_cnt[i] == max_r[i]) res = 1;
        end
      end
      if (res) begin
        m_state[i] = win ? 2 : 3;
        m_rv[i] = 1;
        m_rw[i] = win;
        if (win && m_wins[i] < cmax[i]) m_wins[i]++;
        if (!win && m_losses[i] < cmax[i]) m_losses[i]++;
      end
      if (c) begin m_wins[i] = 0; m_losses[i] = 0; end
    end
  endtask

  task automatic cmp(input int i, input int st, input int pt, input int pv,
                     input int rv, input int rw, input int er, input int w,
                     input int l, input int rc);
    string p;
    p = (i == 0) ? "d0" : "d1";
    check({p, ".state"},        st, m_state[i]);
    check({p, ".point"},        pt, m_point[i]);
    check({p, ".point_valid"},  pv, int'(m_state[i] == 1));
    check({p, ".result_valid"}, rv, m_rv[i]);
    check({p, ".result_win"},   rw, m_rw[i]);
    check({p, ".roll_err"},     er, m_err[i]);
    check({p, ".wins"},         w,  m_wins[i]);
    check({p, ".losses"},       l,  m_losses[i]);
    check({p, ".roll_count"},   rc, m_cnt[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, int'(d0_state), int'(d0_point), int'(d0_pv), int'(d0_rv), int'(d0_rw),
        int'(d0_err), int'(d0_wins), int'(d0_losses), int'(d0_rc));
    cmp(1, int'(d1_state), int'(d1_point), int'(d1_pv), int'(d1_rv), int'(d1_rw),
        int'(d1_err), int'(d1_wins), int'(d1_losses), int'(d1_rc));
  end

  // Apply inputs for one rising edge; returns just after the following negedge.
  task automatic cyc(input bit v, input int s, input bit c);
    roll_valid  = v;
    roll_sum    = 4'(s);
    clear_stats = c;
    model_step(v, s, c);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    roll_valid = 0; clear_stats = 0;
    reset = 1;
    model_reset();
    #1;
    check("rst.state",   int'(d0_state), 0);
    check("rst.rv",      int'(d0_rv), 0);
    check("rst.point",   int'(d0_point), 0);
    check("rst.wins",    int'(d0_wins), 0);
    check("rst.rc",      int'(d0_rc), 0);
    @(negedge clk); #1;
    reset = 0;
  endtask

  initial begin
    reset = 1; roll_valid = 0; roll_sum = '0; clear_stats = 0;
    model_reset();
    @(negedge clk); #1;
    do_reset();
    check("init.state", int'(d0_state), 0);

    // Come-out 7, 11, 2.
    cyc(1, 7, 0);
    check("co7.rv", int'(d0_rv), 1);
    check("co7.rw", int'(d0_rw), 1);
    cyc(1, 11, 0);
    cyc(1, 2, 0);
    check("co.wins",   int'(d0_wins), 2);
    check("co.losses", int'(d0_losses), 1);
    check("co.state",  int'(d0_state), 3);
    check("co.rw",     int'(d0_rw), 0);

    // Point 6, miss 8, hit 6, then come-out 7.
    cyc(1, 6, 0);
    cyc(1, 8, 0);
    check("pt.state", int'(d0_state), 1);
    check("pt.point", int'(d0_point), 6);
    check("pt.rc",    int'(d0_rc), 2);
    cyc(1, 6, 0);
    check("pt.win",   int'(d0_state), 2);
    cyc(1, 7, 0);
    check("pt.co7",   int'(d0_state), 2);
    check("pt.co7rv", int'(d0_rv), 1);

    // Point 4 sevens out; out-of-range rolls only flag an error.
    cyc(1, 4, 0);
    cyc(1, 7, 0);
    check("seven.state",  int'(d0_state), 3);
    check("seven.rw",     int'(d0_rw), 0);
    check("seven.losses", int'(d0_losses), 2);
    cyc(1, 13, 0);
    check("err13", int'(d0_err), 1);
    check("err13.state", int'(d0_state), 3);
    cyc(1, 1, 0);
    check("err1", int'(d0_err), 1);
    cyc(0, 0, 0);
    check("idle.err", int'(d0_err), 0);

    // 5, 9, 10: timeout on dut1 (MAX_ROLLS=3), still POINT on dut0.
    cyc(1, 5, 0);
    cyc(1, 9, 0);
    cyc(1, 10, 0);
    check("to.d1state", int'(d1_state), 3);
    check("to.d1rv",    int'(d1_rv), 1);
    check("to.d0state", int'(d0_state), 1);
    check("to.d0rc",    int'(d0_rc), 3);

    // Clear coincident with a winning come-out.
    cyc(1, 7, 0);
    cyc(1, 7, 1);
    check("clr.rv",     int'(d0_rv), 1);
    check("clr.wins0",  int'(d0_wins), 0);
    check("clr.wins1",  int'(d1_wins), 0);

    // Four wins: 2-bit tally saturates at 3.
    repeat (4) cyc(1, 7, 0);
    check("sat.d1wins", int'(d1_wins), 3);
    check("sat.d0wins", int'(d0_wins), 4);

    // Reset in POINT.
    cyc(1, 6, 0);
    check("mid.state", int'(d0_state), 1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
            $urandom_range(0, 39) == 0);
      end
    end
    cyc(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
